// File: rtl/ysyx_22040088_defs.sv
// Shared LSU definitions: size masks, FSM states and registered request/result records.
// Latency: none (types and constants only).
// Backpressure: n/a.
package ysyx_22040088_defs;

    localparam int XLEN = 64;

    // one-hot access size as produced by the control unit
    localparam logic [3:0] MASK_D = 4'b0001;
    localparam logic [3:0] MASK_W = 4'b0010;
    localparam logic [3:0] MASK_H = 4'b0100;
    localparam logic [3:0] MASK_B = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic            wen;
        logic [3:0]      mask;
        logic            uns;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [4:0]      rd;
    } req_t;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic            rf_we;
        logic            err;
    } resp_t;

endpackage

// File: rtl/ysyx_22040088_lsu_if.sv
// EXU request, writeback result and memory bus signals of the load/store unit.
// Latency: none (wiring only).
// Backpressure: valid/ready on request, result, bus request and bus response channels.
interface ysyx_22040088_lsu_if;
    import ysyx_22040088_defs::*;

    logic            in_valid;
    logic            in_ready;
    logic            in_wen;
    logic [3:0]      in_mask;
    logic            in_unsigned;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;
    logic [4:0]      in_rd;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rdata;
    logic [4:0]      out_rd;
    logic            out_rf_we;
    logic            out_err;

    logic            bus_req_valid;
    logic            bus_req_ready;
    logic [XLEN-1:0] bus_addr;
    logic            bus_wen;
    logic [XLEN-1:0] bus_wdata;
    logic [7:0]      bus_wstrb;
    logic            bus_resp_valid;
    logic            bus_resp_ready;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_resp_err;

    modport master (
        input  in_valid, in_wen, in_mask, in_unsigned, in_addr, in_wdata, in_rd,
        output in_ready,
        output out_valid, out_rdata, out_rd, out_rf_we, out_err,
        input  out_ready,
        output bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb, bus_resp_ready,
        input  bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err
    );

    modport slave (
        output in_valid, in_wen, in_mask, in_unsigned, in_addr, in_wdata, in_rd,
        input  in_ready,
        input  out_valid, out_rdata, out_rd, out_rf_we, out_err,
        output out_ready,
        input  bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb, bus_resp_ready,
        output bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err
    );

endinterface

// File: rtl/ysyx_22040088_lsu_align.sv
// Byte-lane alignment: store strobe/data shift, misalign/illegal-size flag, load extract+extend.
// Latency: combinational.
// Backpressure: none.
module ysyx_22040088_lsu_align
    import ysyx_22040088_defs::*;
(
    input  logic [3:0]      mask,
    input  logic [2:0]      off,
    input  logic            uns,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] rdata_ext,
    output logic            bad
);

    logic [XLEN-1:0] lane;
    logic [7:0]      size_strb;

    assign wdata_sh = wdata << {off, 3'b000};
    assign lane     = rdata >> {off, 3'b000};
    assign wstrb    = size_strb << off;

    // a non-one-hot mask falls to default and is flagged like a misalignment
    always_comb begin
        size_strb = 8'h00;
        bad       = 1'b1;
        rdata_ext = '0;
        case (mask)
            MASK_D: begin
                size_strb = 8'hFF;
                bad       = (off != 3'd0);
                rdata_ext = lane;
            end
            MASK_W: begin
                size_strb = 8'h0F;
                bad       = (off[1:0] != 2'd0);
                rdata_ext = {{32{~uns & lane[31]}}, lane[31:0]};
            end
            MASK_H: begin
                size_strb = 8'h03;
                bad       = off[0];
                rdata_ext = {{48{~uns & lane[15]}}, lane[15:0]};
            end
            MASK_B: begin
                size_strb = 8'h01;
                bad       = 1'b0;
                rdata_ext = {{56{~uns & lane[7]}}, lane[7:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: one aligned 64-bit bus transaction per request, extended load data to writeback.
// Latency: accept N -> bus_req_valid N+1 -> out_valid N+3 on a zero-wait bus; N+1 for rejected requests.
// Backpressure: one request in flight; in_ready only in IDLE, bus and result held until their handshakes.
module ysyx_22040088_lsu
    import ysyx_22040088_defs::*;
(
    input logic                 clk,
    input logic                 rst,
    ysyx_22040088_lsu_if.master lsu
);

    lsu_state_t      state, state_nxt;
    req_t            req_q, req_cur;
    resp_t           res_q;
    logic [7:0]      wstrb;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] rdata_ext;
    logic            bad;

    // alignment sees the live request while idle so the reject decision happens at accept
    assign req_cur = (state == IDLE) ? '{wen:   lsu.in_wen,
                                         mask:  lsu.in_mask,
                                         uns:   lsu.in_unsigned,
                                         addr:  lsu.in_addr,
                                         wdata: lsu.in_wdata,
                                         rd:    lsu.in_rd}
                                     : req_q;

    ysyx_22040088_lsu_align u_align (
        .mask      (req_cur.mask),
        .off       (req_cur.addr[2:0]),
        .uns       (req_cur.uns),
        .wdata     (req_cur.wdata),
        .rdata     (lsu.bus_rdata),
        .wstrb     (wstrb),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .bad       (bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        lsu.in_ready       = 1'b0;
        lsu.out_valid      = 1'b0;
        lsu.bus_req_valid  = 1'b0;
        lsu.bus_addr       = '0;
        lsu.bus_wen        = 1'b0;
        lsu.bus_wdata      = '0;
        lsu.bus_wstrb      = 8'h00;
        lsu.bus_resp_ready = 1'b0;
        case (state)
            IDLE: begin
                lsu.in_ready = 1'b1;
                if (lsu.in_valid) state_nxt = bad ? DONE : REQ;
            end
            REQ: begin
                lsu.bus_req_valid = 1'b1;
                lsu.bus_addr      = {req_q.addr[XLEN-1:3], 3'b000};
                lsu.bus_wen       = req_q.wen;
                lsu.bus_wdata     = wdata_sh;
                lsu.bus_wstrb     = req_q.wen ? wstrb : 8'h00;
                if (lsu.bus_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                lsu.bus_resp_ready = 1'b1;
                if (lsu.bus_resp_valid) state_nxt = DONE;
            end
            DONE: begin
                lsu.out_valid = 1'b1;
                if (lsu.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
            res_q <= '0;
        end else if (state == IDLE && lsu.in_valid) begin
            req_q <= req_cur;
            res_q <= '{rdata: '0, rf_we: 1'b0, err: bad};
        end else if (state == WAIT && lsu.bus_resp_valid) begin
            res_q.err   <= lsu.bus_resp_err;
            res_q.rf_we <= ~lsu.bus_resp_err & ~req_q.wen & (req_q.rd != 5'd0);
            res_q.rdata <= (lsu.bus_resp_err | req_q.wen) ? '0 : rdata_ext;
        end
    end

    assign lsu.out_rdata = res_q.rdata;
    assign lsu.out_rf_we = res_q.rf_we;
    assign lsu.out_err   = res_q.err;
    assign lsu.out_rd    = req_q.rd;

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Self-checking bench for the load/store unit: directed cases, backpressure, reset abort, random traffic.
module tb_ysyx_22040088_lsu;
    import ysyx_22040088_defs::*;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ysyx_22040088_lsu_if ifc ();

    ysyx_22040088_lsu dut (
        .clk (clk),
        .rst (rst),
        .lsu (ifc)
    );

    always #5 clk = ~clk;

    // observations of the most recent transaction
    logic [63:0] o_rdata, o_baddr, o_bwdata;
    logic [7:0]  o_bstrb;
    logic [4:0]  o_rd;
    logic        o_rf_we, o_err, o_bwen;
    int          o_lat, o_hs;
    bit          o_seen_req, o_bus_unstable, o_out_unstable, o_inrdy_bad, o_timeout;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // size in bytes of a one-hot mask, 0 when the mask is not one-hot
    function automatic int msize(input logic [3:0] m);
        int n = 0;
        if ($countones(m) == 1)
            for (int i = 0; i < 4; i++) if (m[i]) n = 8 >> i;
        return n;
    endfunction

    function automatic logic [63:0] model_load(input logic [3:0] m, input logic uns,
                                               input int off, input logic [63:0] word);
        int          sz = msize(m);
        logic [63:0] r  = '0;
        for (int i = 0; i < sz; i++) r[8*i +: 8] = word[8*(off+i) +: 8];
        if (!uns && sz < 8 && r[8*sz-1])
            for (int i = 8*sz; i < 64; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] model_strb(input logic [3:0] m, input int off);
        logic [7:0] s = '0;
        for (int i = 0; i < msize(m); i++) s[off+i] = 1'b1;
        return s;
    endfunction

    // drives one request and plays bus + writeback; records what it saw, checks nothing itself
    task automatic run_txn(input logic wen, input logic [3:0] mask, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                           input logic [63:0] rdata, input logic rerr,
                           input int req_dly, input int resp_dly, input int out_dly);
        int cyc, rq, rs, oq;
        bit done;
        o_timeout = 0; o_seen_req = 0; o_bus_unstable = 0; o_out_unstable = 0;
        o_inrdy_bad = 0; o_lat = -1; o_hs = 0;
        cyc = 0;
        while (ifc.in_ready !== 1'b1 && cyc < 20) begin step(); cyc++; end
        if (ifc.in_ready !== 1'b1) o_timeout = 1;
        ifc.in_valid = 1'b1; ifc.in_wen = wen; ifc.in_mask = mask; ifc.in_unsigned = uns;
        ifc.in_addr = addr; ifc.in_wdata = wdata; ifc.in_rd = rd;
        step();
        ifc.in_valid = 1'b0; ifc.in_wen = 1'($urandom); ifc.in_mask = 4'($urandom);
        ifc.in_unsigned = 1'($urandom); ifc.in_addr = {$urandom, $urandom};
        ifc.in_wdata = {$urandom, $urandom}; ifc.in_rd = 5'($urandom);
        cyc = 1; rq = 0; rs = 0; oq = 0; done = 0;
        while (!done && cyc < 100) begin
            ifc.bus_req_ready  = 1'b0;
            ifc.out_ready      = 1'b0;
            ifc.bus_resp_valid = 1'($urandom);
            ifc.bus_resp_err   = 1'b1;
            ifc.bus_rdata      = {$urandom, $urandom};
            if (ifc.in_ready) o_inrdy_bad = 1;
            if (ifc.bus_req_valid) begin
                if (!o_seen_req) begin
                    o_seen_req = 1; o_baddr = ifc.bus_addr; o_bwen = ifc.bus_wen;
                    o_bwdata = ifc.bus_wdata; o_bstrb = ifc.bus_wstrb;
                end else if (ifc.bus_addr !== o_baddr || ifc.bus_wen !== o_bwen ||
                             ifc.bus_wdata !== o_bwdata || ifc.bus_wstrb !== o_bstrb)
                    o_bus_unstable = 1;
                if (rq >= req_dly) begin ifc.bus_req_ready = 1'b1; o_hs++; end
                rq++;
            end
            if (ifc.bus_resp_ready) begin
                ifc.bus_resp_valid = (rs >= resp_dly);
                ifc.bus_resp_err   = rerr;
                if (rs >= resp_dly) ifc.bus_rdata = rdata;
                rs++;
            end
            if (ifc.out_valid) begin
                if (o_lat < 0) begin
                    o_lat = cyc; o_rdata = ifc.out_rdata; o_rf_we = ifc.out_rf_we;
                    o_err = ifc.out_err; o_rd = ifc.out_rd;
                end else if (ifc.out_rdata !== o_rdata || ifc.out_rf_we !== o_rf_we ||
                             ifc.out_err !== o_err || ifc.out_rd !== o_rd)
                    o_out_unstable = 1;
                if (oq >= out_dly) begin ifc.out_ready = 1'b1; done = 1; end
                oq++;
            end
            step();
            cyc++;
        end
        if (!done) o_timeout = 1;
        ifc.bus_req_ready = 1'b0; ifc.bus_resp_valid = 1'b0; ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", ifc.in_ready); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ifc.out_valid); end
        total++; if (ifc.bus_req_valid !== 1'b0) begin bad++; $display("FAIL reset_bus_req_valid got=%b exp=0", ifc.bus_req_valid); end
        total++; if (ifc.bus_resp_ready !== 1'b0) begin bad++; $display("FAIL reset_bus_resp_ready got=%b exp=0", ifc.bus_resp_ready); end
        rst = 1'b0;
        step();
        total++; if (ifc.out_rdata !== 64'h0) begin bad++; $display("FAIL reset_out_rdata got=%h exp=0", ifc.out_rdata); end
        total++; if ({ifc.out_err, ifc.out_rf_we, ifc.out_rd} !== 7'h0) begin bad++; $display("FAIL reset_out_flags got=%b/%b/%0d exp=0", ifc.out_err, ifc.out_rf_we, ifc.out_rd); end
        total++; if ({ifc.bus_addr, ifc.bus_wdata, ifc.bus_wstrb, ifc.bus_wen} !== '0) begin bad++; $display("FAIL reset_bus_fields got=%h/%h/%h/%b exp=0", ifc.bus_addr, ifc.bus_wdata, ifc.bus_wstrb, ifc.bus_wen); end
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL reset_idle_in_ready got=%b exp=1", ifc.in_ready); end
    endtask

    task automatic test_load();
        run_txn(1'b0, MASK_D, 1'b0, 64'h8000_0000, 64'h0, 5'd5, 64'h1122334455667788, 1'b0, 0, 0, 0);
        total++; if (o_timeout) begin bad++; $display("FAIL ld_timeout got=1 exp=0"); end
        total++; if (o_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL ld_rdata got=%h exp=1122334455667788", o_rdata); end
        total++; if (o_rf_we !== 1'b1 || o_err !== 1'b0 || o_rd !== 5'd5) begin bad++; $display("FAIL ld_flags got=we%b err%b rd%0d exp=we1 err0 rd5", o_rf_we, o_err, o_rd); end
        total++; if (o_lat != 3) begin bad++; $display("FAIL ld_latency got=%0d exp=3", o_lat); end
        total++; if (o_baddr !== 64'h8000_0000 || o_bwen !== 1'b0 || o_bstrb !== 8'h00) begin bad++; $display("FAIL ld_bus got=%h/%b/%h exp=80000000/0/00", o_baddr, o_bwen, o_bstrb); end
        run_txn(1'b0, MASK_W, 1'b0, 64'h8000_0004, 64'h0, 5'd7, 64'h8000000012345678, 1'b0, 0, 0, 0);
        total++; if (o_rdata !== 64'hFFFFFFFF80000000) begin bad++; $display("FAIL lw_rdata got=%h exp=ffffffff80000000", o_rdata); end
        total++; if (o_baddr !== 64'h8000_0000) begin bad++; $display("FAIL lw_bus_addr got=%h exp=80000000", o_baddr); end
        run_txn(1'b0, MASK_W, 1'b1, 64'h8000_0004, 64'h0, 5'd7, 64'h8000000012345678, 1'b0, 0, 0, 0);
        total++; if (o_rdata !== 64'h0000000080000000) begin bad++; $display("FAIL lwu_rdata got=%h exp=0000000080000000", o_rdata); end
        run_txn(1'b0, MASK_B, 1'b0, 64'h8000_0007, 64'h0, 5'd0, 64'h80FF_0000_0000_0000, 1'b0, 0, 0, 0);
        total++; if (o_rdata !== 64'hFFFFFFFFFFFFFF80 || o_rf_we !== 1'b0) begin bad++; $display("FAIL lb_rd0 got=%h we%b exp=ffffffffffffff80 we0", o_rdata, o_rf_we); end
    endtask

    task automatic test_store();
        run_txn(1'b1, MASK_B, 1'b0, 64'h8000_0003, 64'hAB, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0, 0);
        total++; if (o_baddr !== 64'h8000_0000 || o_bwen !== 1'b1) begin bad++; $display("FAIL sb_bus_addr got=%h/%b exp=80000000/1", o_baddr, o_bwen); end
        total++; if (o_bstrb !== 8'h08) begin bad++; $display("FAIL sb_wstrb got=%h exp=08", o_bstrb); end
        total++; if (o_bwdata !== 64'h00000000AB000000) begin bad++; $display("FAIL sb_wdata got=%h exp=00000000ab000000", o_bwdata); end
        total++; if (o_rf_we !== 1'b0 || o_rdata !== 64'h0 || o_err !== 1'b0) begin bad++; $display("FAIL sb_result got=we%b %h err%b exp=we0 0 err0", o_rf_we, o_rdata, o_err); end
        run_txn(1'b0, MASK_D, 1'b0, 64'h8000_0008, 64'h0, 5'd3, 64'h1234, 1'b1, 0, 0, 0);
        total++; if (o_err !== 1'b1 || o_rf_we !== 1'b0 || o_rdata !== 64'h0 || o_lat != 3) begin bad++; $display("FAIL bus_err got=err%b we%b %h lat%0d exp=err1 we0 0 lat3", o_err, o_rf_we, o_rdata, o_lat); end
    endtask

    task automatic test_misaligned();
        logic [3:0]  masks [4] = '{MASK_H, 4'b0000, 4'b0011, MASK_W};
        logic [63:0] addrs [4] = '{64'h8000_0001, 64'h8000_0000, 64'h8000_0000, 64'h8000_0002};
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, masks[i], 1'b0, addrs[i], 64'h55, 5'd4, 64'h0, 1'b0, 0, 0, 1);
            total++; if (o_err !== 1'b1 || o_rf_we !== 1'b0 || o_rdata !== 64'h0) begin bad++; $display("FAIL reject_result[%0d] got=err%b we%b %h exp=err1 we0 0", i, o_err, o_rf_we, o_rdata); end
            total++; if (o_lat != 1) begin bad++; $display("FAIL reject_latency[%0d] got=%0d exp=1", i, o_lat); end
            total++; if (o_seen_req) begin bad++; $display("FAIL reject_no_bus[%0d] got=req seen exp=none", i); end
        end
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, MASK_W, 1'b1, 64'h8000_0014, 64'h0, 5'd12, 64'hDEADBEEF_00000000, 1'b0, 3, 2, 2);
        total++; if (o_timeout) begin bad++; $display("FAIL bp_timeout got=1 exp=0"); end
        total++; if (o_hs != 1) begin bad++; $display("FAIL bp_handshakes got=%0d exp=1", o_hs); end
        total++; if (o_bus_unstable || o_out_unstable) begin bad++; $display("FAIL bp_stable got=bus%b out%b exp=0/0", o_bus_unstable, o_out_unstable); end
        total++; if (o_inrdy_bad) begin bad++; $display("FAIL bp_in_ready got=1 while busy exp=0"); end
        total++; if (o_lat != 8) begin bad++; $display("FAIL bp_latency got=%0d exp=8", o_lat); end
        total++; if (o_rdata !== 64'h00000000DEADBEEF || o_baddr !== 64'h8000_0010) begin bad++; $display("FAIL bp_data got=%h @%h exp=00000000deadbeef @80000010", o_rdata, o_baddr); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (ifc.in_ready !== 1'b1 && n < 20) begin step(); n++; end
        ifc.in_valid = 1'b1; ifc.in_wen = 1'b0; ifc.in_mask = MASK_D; ifc.in_unsigned = 1'b0;
        ifc.in_addr = 64'h8000_0100; ifc.in_rd = 5'd1;
        step();
        ifc.in_valid = 1'b0; ifc.bus_req_ready = 1'b1;
        step();
        ifc.bus_req_ready = 1'b0;
        step();
        total++; if (ifc.bus_resp_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_wait got=%b exp=1", ifc.bus_resp_ready); end
        #1 rst = 1'b1;
        #1;
        total++; if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0 || ifc.bus_resp_ready !== 1'b0) begin bad++; $display("FAIL rstmid_async got=rdy%b ov%b rr%b exp=1/0/0", ifc.in_ready, ifc.out_valid, ifc.bus_resp_ready); end
        step();
        rst = 1'b0;
        ifc.bus_resp_valid = 1'b1; ifc.bus_resp_err = 1'b0; ifc.bus_rdata = 64'hCAFE;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.bus_req_valid !== 1'b0) begin bad++; $display("FAIL rstmid_late_resp[%0d] got=ov%b rdy%b rv%b exp=0/1/0", i, ifc.out_valid, ifc.in_ready, ifc.bus_req_valid); end
        end
        ifc.bus_resp_valid = 1'b0;
        run_txn(1'b0, MASK_H, 1'b0, 64'h8000_0106, 64'h0, 5'd2, 64'h7FFF_0000_0000_0000, 1'b0, 0, 0, 0);
        total++; if (o_rdata !== 64'h0000_0000_0000_7FFF || o_lat != 3) begin bad++; $display("FAIL rstmid_recover got=%h lat%0d exp=0000000000007fff lat3", o_rdata, o_lat); end
    endtask

    task automatic test_random();
        logic        wen, uns, rerr, legal;
        logic [3:0]  mask;
        logic [4:0]  rd;
        logic [63:0] addr, wdata, rdata, e_rdata;
        int          sz, off, rqd, rsd, otd, e_lat;
        for (int n = 0; n < 80; n++) begin
            wen = 1'($urandom); uns = 1'($urandom); rd = 5'($urandom);
            mask = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            addr = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFF8)} | 64'($urandom_range(0, 7));
            sz = msize(mask);
            off = int'(addr[2:0]);
            if (sz != 0 && $urandom_range(0, 3) != 0) begin
                off = (off / sz) * sz;
                addr[2:0] = 3'(off);
            end
            wdata = {$urandom, $urandom}; rdata = {$urandom, $urandom};
            rerr = ($urandom_range(0, 7) == 0);
            rqd = $urandom_range(0, 3); rsd = $urandom_range(0, 3); otd = $urandom_range(0, 2);
            legal = (sz != 0) && (off % sz == 0);
            e_lat = legal ? 3 + rqd + rsd : 1;
            e_rdata = (!legal || rerr || wen) ? 64'h0 : model_load(mask, uns, off, rdata);
            run_txn(wen, mask, uns, addr, wdata, rd, rdata, rerr, rqd, rsd, otd);
            total++; if (o_timeout) begin bad++; $display("FAIL rnd_timeout[%0d] got=1 exp=0", n); end
            total++; if (o_err !== (!legal || rerr)) begin bad++; $display("FAIL rnd_err[%0d] got=%b exp=%b", n, o_err, !legal || rerr); end
            total++; if (o_rdata !== e_rdata) begin bad++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", n, o_rdata, e_rdata); end
            total++; if (o_rf_we !== (legal && !rerr && !wen && rd != 0)) begin bad++; $display("FAIL rnd_rf_we[%0d] got=%b", n, o_rf_we); end
            total++; if (o_rd !== rd) begin bad++; $display("FAIL rnd_rd[%0d] got=%0d exp=%0d", n, o_rd, rd); end
            total++; if (o_lat != e_lat) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", n, o_lat, e_lat); end
            total++; if (o_seen_req != legal || (legal && o_hs != 1)) begin bad++; $display("FAIL rnd_bus_txn[%0d] got=seen%b hs%0d exp=seen%b", n, o_seen_req, o_hs, legal); end
            total++; if (o_bus_unstable || o_out_unstable || o_inrdy_bad) begin bad++; $display("FAIL rnd_hold[%0d] got=bus%b out%b rdy%b exp=0", n, o_bus_unstable, o_out_unstable, o_inrdy_bad); end
            if (legal) begin
                total++; if (o_baddr !== (addr & ~64'h7) || o_bwen !== wen) begin bad++; $display("FAIL rnd_bus_addr[%0d] got=%h/%b exp=%h/%b", n, o_baddr, o_bwen, addr & ~64'h7, wen); end
                total++; if (o_bstrb !== (wen ? model_strb(mask, off) : 8'h00)) begin bad++; $display("FAIL rnd_wstrb[%0d] got=%h", n, o_bstrb); end
                if (wen) begin
                    total++; if (o_bwdata !== (wdata << (8 * off))) begin bad++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", n, o_bwdata, wdata << (8 * off)); end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finished");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        clk = 1'b0; rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_wen = 1'b0; ifc.in_mask = 4'h0; ifc.in_unsigned = 1'b0;
        ifc.in_addr = '0; ifc.in_wdata = '0; ifc.in_rd = '0; ifc.out_ready = 1'b0;
        ifc.bus_req_ready = 1'b0; ifc.bus_resp_valid = 1'b0; ifc.bus_rdata = '0; ifc.bus_resp_err = 1'b0;
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
